// File: rtl/pipeline_stage_buffer_if.sv
// Valid/ready handshake bundle between two core pipeline stages.
// The buffer takes the slave side; the producer/consumer side uses master.
interface pipeline_stage_buffer_if #(
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic              in_invalid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_invalid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid, in_invalid, in_data, out_ready,
        input  in_ready, out_valid, out_invalid, out_data
    );

    modport slave (
        input  in_valid, in_invalid, in_data, out_ready,
        output in_ready, out_valid, out_invalid, out_data
    );
endinterface

// File: rtl/pipeline_stage_buffer.sv
// Elastic pipeline stage: DEPTH-entry circular buffer of {invalid, data} with
// valid/ready handshake, flush, and fully registered outputs on both sides.
module pipeline_stage_buffer #(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 2,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    pipeline_stage_buffer_if.slave bus,
    output logic [CNT_W-1:0]     count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned ENT_W = DATA_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    logic [ENT_W-1:0]  mem [DEPTH];
    ptr_t              rd_ptr, wr_ptr, rd_n, wr_n;
    logic [CNT_W-1:0]  cnt_n;
    logic              in_ready_q, out_valid_q, out_invalid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              in_ready_n, out_valid_n, out_invalid_n;
    logic [DATA_W-1:0] out_data_n;
    logic              push, pop, mem_we;
    logic [ENT_W-1:0]  head_n;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : ptr_t'(p + PTR_W'(1));
    endfunction

    // Next-state: occupancy, pointers, and the head entry as it will be after this edge
    always_comb begin
        push       = bus.in_valid && in_ready_q;
        pop        = out_valid_q && bus.out_ready;
        mem_we     = rst_n && push && !flush;
        cnt_n      = count;
        rd_n       = rd_ptr;
        wr_n       = wr_ptr;
        if (flush) begin
            cnt_n = '0;
            rd_n  = '0;
            wr_n  = '0;
        end else begin
            if (push) wr_n = ptr_inc(wr_ptr);
            if (pop)  rd_n = ptr_inc(rd_ptr);
            if (push && !pop)      cnt_n = count + CNT_W'(1);
            else if (pop && !push) cnt_n = count - CNT_W'(1);
        end
        // A write landing on the new head slot is forwarded, since mem updates at the same edge
        head_n        = (mem_we && (rd_n == wr_ptr)) ? {bus.in_invalid, bus.in_data} : mem[rd_n];
        in_ready_n    = (cnt_n < CNT_W'(DEPTH));
        out_valid_n   = (cnt_n != '0);
        out_invalid_n = (cnt_n == '0) ? 1'b1 : head_n[DATA_W];
        out_data_n    = (cnt_n == '0) ? out_data_q : head_n[DATA_W-1:0];
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_invalid_q <= 1'b1;
            out_data_q    <= '0;
        end else begin
            count         <= cnt_n;
            rd_ptr        <= rd_n;
            wr_ptr        <= wr_n;
            in_ready_q    <= in_ready_n;
            out_valid_q   <= out_valid_n;
            out_invalid_q <= out_invalid_n;
            out_data_q    <= out_data_n;
        end
    end

    // Entry storage; written only by an accepted push
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr] <= {bus.in_invalid, bus.in_data};
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_invalid = out_invalid_q;
    assign bus.out_data    = out_data_q;
endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Directed bench for pipeline_stage_buffer: vector table on a DEPTH=2 stage,
// streaming loop, and a queue-modelled wrap sequence on a DEPTH=3 stage.
module tb_pipeline_stage_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [1:0] count2;
    logic [1:0] count3;
    int n_checks = 0;
    int n_fail   = 0;

    pipeline_stage_buffer_if #(.DATA_W(32)) b2 ();
    pipeline_stage_buffer_if #(.DATA_W(32)) b3 ();

    pipeline_stage_buffer #(.DATA_W(32), .DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b2), .count(count2));
    pipeline_stage_buffer #(.DATA_W(32), .DEPTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b3), .count(count3));

    always #5 clk = ~clk;

    typedef struct {
        bit          rst_n;
        bit          flush;
        bit          iv;
        bit          iinv;
        logic [31:0] d;
        bit          ordy;
        int          cnt;
        bit          ov;
        bit          oinv;
        logic [31:0] od;
        bit          ir;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int q[$];
        logic [31:0] last;
        logic [31:0] d;
        bit ops_iv[14] = '{1,1,1,0,1,1,1,1,1,1,0,0,0,0};
        bit ops_or[14] = '{0,0,1,1,1,0,0,0,1,1,1,1,1,1};

        b2.in_valid = 1'b0; b2.in_invalid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b0;
        b3.in_valid = 1'b0; b3.in_invalid = 1'b0; b3.in_data = '0; b3.out_ready = 1'b0;

        //             rst fl iv inv data        ordy cnt ov inv od          ir
        tbl.push_back('{0, 0, 1, 0, 32'h99, 0,  0,  0, 1, 32'h0,  1});
        tbl.push_back('{0, 0, 1, 0, 32'h99, 0,  0,  0, 1, 32'h0,  1});
        tbl.push_back('{1, 0, 1, 0, 32'hA1, 0,  1,  1, 0, 32'hA1, 1});
        tbl.push_back('{1, 0, 1, 0, 32'hA2, 0,  2,  1, 0, 32'hA1, 0});
        tbl.push_back('{1, 0, 1, 0, 32'hA3, 0,  2,  1, 0, 32'hA1, 0});
        tbl.push_back('{1, 0, 0, 0, 32'h0,  1,  1,  1, 0, 32'hA2, 1});
        tbl.push_back('{1, 0, 0, 0, 32'h0,  1,  0,  0, 1, 32'hA2, 1});
        tbl.push_back('{1, 0, 1, 0, 32'hA4, 0,  1,  1, 0, 32'hA4, 1});
        tbl.push_back('{1, 0, 1, 0, 32'hA5, 0,  2,  1, 0, 32'hA4, 0});
        tbl.push_back('{1, 0, 1, 0, 32'hA6, 1,  1,  1, 0, 32'hA5, 1});
        tbl.push_back('{1, 0, 0, 0, 32'h0,  1,  0,  0, 1, 32'hA5, 1});
        tbl.push_back('{1, 0, 1, 0, 32'hB1, 0,  1,  1, 0, 32'hB1, 1});
        tbl.push_back('{1, 0, 1, 0, 32'hB2, 0,  2,  1, 0, 32'hB1, 0});
        tbl.push_back('{1, 1, 1, 0, 32'hFF, 1,  0,  0, 1, 32'hB1, 1});
        tbl.push_back('{1, 0, 0, 0, 32'h0,  1,  0,  0, 1, 32'hB1, 1});
        tbl.push_back('{1, 0, 1, 0, 32'hD1, 0,  1,  1, 0, 32'hD1, 1});
        tbl.push_back('{1, 1, 1, 0, 32'hFE, 1,  0,  0, 1, 32'hD1, 1});
        tbl.push_back('{1, 0, 0, 0, 32'h0,  1,  0,  0, 1, 32'hD1, 1});
        tbl.push_back('{1, 0, 1, 1, 32'h33, 0,  1,  1, 1, 32'h33, 1});
        tbl.push_back('{1, 0, 1, 0, 32'h55, 0,  2,  1, 1, 32'h33, 0});
        tbl.push_back('{1, 0, 0, 0, 32'h0,  1,  1,  1, 0, 32'h55, 1});
        tbl.push_back('{1, 0, 1, 0, 32'h66, 0,  2,  1, 0, 32'h55, 0});
        tbl.push_back('{0, 0, 1, 0, 32'h77, 1,  0,  0, 1, 32'h0,  1});
        tbl.push_back('{1, 0, 0, 0, 32'h0,  0,  0,  0, 1, 32'h0,  1});

        foreach (tbl[i]) begin
            rst_n         = tbl[i].rst_n;
            flush         = tbl[i].flush;
            b2.in_valid   = tbl[i].iv;
            b2.in_invalid = tbl[i].iinv;
            b2.in_data    = tbl[i].d;
            b2.out_ready  = tbl[i].ordy;
            tick();
            check($sformatf("vec%0d.count", i),       32'(count2),         32'(tbl[i].cnt));
            check($sformatf("vec%0d.out_valid", i),   32'(b2.out_valid),   32'(tbl[i].ov));
            check($sformatf("vec%0d.out_invalid", i), 32'(b2.out_invalid), 32'(tbl[i].oinv));
            check($sformatf("vec%0d.out_data", i),    b2.out_data,         tbl[i].od);
            check($sformatf("vec%0d.in_ready", i),    32'(b2.in_ready),    32'(tbl[i].ir));
            if (i == 1) begin
                check("d3_reset.count",     32'(count3),         32'h0);
                check("d3_reset.out_valid", 32'(b3.out_valid),   32'h0);
                check("d3_reset.out_data",  b3.out_data,         32'h0);
                check("d3_reset.in_ready",  32'(b3.in_ready),    32'h1);
            end
        end

        // Back-to-back stream with downstream always ready
        b2.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b2.in_valid   = 1'b1;
            b2.in_invalid = 1'b0;
            b2.in_data    = 32'h10 + 32'(i);
            tick();
            check($sformatf("stream%0d.count", i),     32'(count2),       32'h1);
            check($sformatf("stream%0d.out_valid", i), 32'(b2.out_valid), 32'h1);
            check($sformatf("stream%0d.out_data", i),  b2.out_data,       32'h10 + 32'(i));
        end
        b2.in_valid = 1'b0;
        tick();
        check("stream_end.count",     32'(count2),       32'h0);
        check("stream_end.out_valid", 32'(b2.out_valid), 32'h0);
        check("stream_end.out_data",  b2.out_data,       32'h1F);

        // DEPTH=3 wrap against a FIFO queue model
        last = 32'h0;
        d    = 32'h30;
        for (int i = 0; i < 14; i++) begin
            bit acc_push, acc_pop;
            acc_push      = ops_iv[i] && (q.size() < 3);
            acc_pop       = ops_or[i] && (q.size() != 0);
            b3.in_valid   = ops_iv[i];
            b3.in_invalid = 1'b0;
            b3.in_data    = d;
            b3.out_ready  = ops_or[i];
            tick();
            if (acc_pop)  void'(q.pop_front());
            if (acc_push) q.push_back(int'(d));
            if (q.size() != 0) last = 32'(q[0]);
            if (acc_push) d = d + 32'h1;
            check($sformatf("wrap%0d.count", i),     32'(count3),       32'(q.size()));
            check($sformatf("wrap%0d.out_valid", i), 32'(b3.out_valid), 32'(q.size() != 0));
            check($sformatf("wrap%0d.out_data", i),  b3.out_data,       last);
            check($sformatf("wrap%0d.in_ready", i),  32'(b3.in_ready),  32'(q.size() < 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
